apb_req_arbiter: RTL and testbench

//  Shares the single APB bridge between NREQ on-chip requesters (TB sequencer, coefficient loader, DFE config FSMs).

---
 rtl/apb_req_arbiter_if.sv | 35 +++
 rtl/apb_req_arbiter.sv | 157 +++++++++++++++
 tb/tb_apb_req_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_arbiter_if.sv
// Requester-side and bridge-side signals of the APB request arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface apb_req_arbiter_if #(
  parameter int NREQ       = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int COMP       = 4
);
  logic [NREQ-1:0]            req;
  logic [NREQ-1:0]            req_write;
  logic [NREQ*ADDR_WIDTH-1:0] req_addr;
  logic [NREQ*DATA_WIDTH-1:0] req_wdata;
  logic [NREQ*COMP-1:0]       req_sel;
  logic [NREQ-1:0]            gnt;
  logic [NREQ-1:0]            done;
  logic [DATA_WIDTH-1:0]      rdata;
  logic                       busy;
  logic                       MTRANS;
  logic                       MWRITE;
  logic [COMP-1:0]            MSELx;
  logic [ADDR_WIDTH-1:0]      MADDR;
  logic [DATA_WIDTH-1:0]      MWDATA;
  logic                       PREADY;
  logic [DATA_WIDTH-1:0]      MRDATA;

  modport master (
    input  req, req_write, req_addr, req_wdata, req_sel, PREADY, MRDATA,
    output gnt, done, rdata, busy, MTRANS, MWRITE, MSELx, MADDR, MWDATA
  );

  modport slave (
    output req, req_write, req_addr, req_wdata, req_sel, PREADY, MRDATA,
    input  gnt, done, rdata, busy, MTRANS, MWRITE, MSELx, MADDR, MWDATA
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Shares one APB bridge between NREQ requesters, one transfer in flight at a time.
// Define APB_ARB_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
module apb_req_arbiter #(
  parameter int NREQ       = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int COMP       = 4
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_req_arbiter_if.master bus
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t                r_state;
  logic [PW-1:0]         r_winner;
  logic [NREQ-1:0]       r_done;
  logic                  r_mtrans;
  logic                  r_mwrite;
  logic [COMP-1:0]       r_msel;
  logic [ADDR_WIDTH-1:0] r_maddr;
  logic [DATA_WIDTH-1:0] r_mwdata;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_found;
  logic [PW-1:0]         w_winner;
  logic [PW-1:0]         w_idx;
  logic [NREQ-1:0]       w_gnt;
  logic                  w_write;
  logic [COMP-1:0]       w_sel;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;

`ifndef APB_ARB_FIXED_PRIO_EN
  logic [PW-1:0]         r_ptr;
  logic [PW-1:0]         w_next_ptr;
`endif

  // Pick the first pending request, scanning from the RR pointer or from index 0.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef APB_ARB_FIXED_PRIO_EN
      w_idx = PW'(k);
`else
      w_idx = PW'((int'(r_ptr) + k) % NREQ);
`endif
      if (!w_found && bus.req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

`ifndef APB_ARB_FIXED_PRIO_EN
  assign w_next_ptr = (w_winner == PW'(NREQ - 1)) ? '0 : w_winner + 1'b1;
`endif

  always_comb begin
    w_write = 1'b0;
    w_sel   = '0;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_winner == PW'(i)) begin
        w_write = bus.req_write[i];
        w_sel   = bus.req_sel[i*COMP +: COMP];
        w_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Grant is issued in the IDLE cycle itself so it can share the cycle with the previous done.
  always_comb begin
    w_gnt = '0;
    if (r_state == S_IDLE && w_found && !PRESET) begin
      w_gnt[w_winner] = 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state  <= S_IDLE;
      r_winner <= '0;
      r_done   <= '0;
      r_mtrans <= 1'b0;
      r_mwrite <= 1'b0;
      r_msel   <= '0;
      r_maddr  <= '0;
      r_mwdata <= '0;
      r_rdata  <= '0;
`ifndef APB_ARB_FIXED_PRIO_EN
      r_ptr    <= '0;
`endif
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_winner <= w_winner;
            r_mwrite <= w_write;
            r_msel   <= w_sel;
            r_maddr  <= w_addr;
            r_mwdata <= w_wdata;
            r_mtrans <= 1'b1;
            r_state  <= S_ISSUE;
`ifndef APB_ARB_FIXED_PRIO_EN
            r_ptr    <= w_next_ptr;
`endif
          end
        end
        S_ISSUE: begin
          r_mtrans <= 1'b0;
          r_state  <= S_SETUP;
        end
        S_SETUP: begin
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          // No timeout: a completer that never raises PREADY stalls the arbiter.
          if (bus.PREADY) begin
            if (!r_mwrite) begin
              r_rdata <= bus.MRDATA;
            end
            r_done[r_winner] <= 1'b1;
            r_state          <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt    = w_gnt;
  assign bus.done   = r_done;
  assign bus.rdata  = r_rdata;
  assign bus.busy   = (r_state != S_IDLE) || (|r_done) || (|w_gnt);
  assign bus.MTRANS = r_mtrans;
  assign bus.MWRITE = r_mwrite;
  assign bus.MSELx  = r_msel;
  assign bus.MADDR  = r_maddr;
  assign bus.MWDATA = r_mwdata;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed self-checking bench for apb_req_arbiter; inputs change 1ns after the
// rising edge and outputs are sampled on the falling edge.
module tb_apb_req_arbiter;

  logic PCLK;
  logic PRESET;
  int   tests;
  int   fails;

  apb_req_arbiter_if #(.NREQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .COMP(4)) bus ();

  apb_req_arbiter #(.NREQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .COMP(4)) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle();
    @(posedge PCLK);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] sel);
    bus.req_write[idx]          = wr;
    bus.req_addr[idx*32 +: 32]  = addr;
    bus.req_wdata[idx*32 +: 32] = wdata;
    bus.req_sel[idx*4 +: 4]     = sel;
    bus.req[idx]                = 1'b1;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    nextCycle();
    nextCycle();
    @(negedge PCLK);
    tests++;
    if ({bus.gnt, bus.done, bus.busy, bus.MTRANS, bus.MWRITE} !== 11'b0) begin
      fails++;
      $display("[TB] FAIL reset_ctrl got %b want 0", {bus.gnt, bus.done, bus.busy, bus.MTRANS, bus.MWRITE});
    end
    tests++;
    if ({bus.MSELx, bus.MADDR, bus.MWDATA} !== 68'b0) begin
      fails++;
      $display("[TB] FAIL reset_mregs got %h want 0", {bus.MSELx, bus.MADDR, bus.MWDATA});
    end
    tests++;
    if (bus.rdata !== 32'h0) begin
      fails++;
      $display("[TB] FAIL reset_rdata got %h want 0", bus.rdata);
    end
    nextCycle();
    PRESET = 1'b0;
  endtask

  task automatic test_single_write();
    logic [3:0] expGnt, expDone;
    logic       expMtrans, expBusy;
    applyStimulus(0, 1'b1, 32'h10, 32'hA5A5_0001, 4'b0001);
    bus.PREADY = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) bus.req = '0;
      @(negedge PCLK);
      expGnt    = (c == 0) ? 4'b0001 : 4'b0000;
      expDone   = (c == 4) ? 4'b0001 : 4'b0000;
      expMtrans = (c == 1);
      expBusy   = (c <= 4);
      tests++;
      if ({bus.gnt, bus.done, bus.MTRANS, bus.busy} !== {expGnt, expDone, expMtrans, expBusy}) begin
        fails++;
        $display("[TB] FAIL wr_ctrl c%0d got gnt=%b done=%b mtrans=%b busy=%b want %b %b %b %b",
                 c, bus.gnt, bus.done, bus.MTRANS, bus.busy, expGnt, expDone, expMtrans, expBusy);
      end
      if (c == 1) begin
        tests++;
        if ({bus.MWRITE, bus.MSELx, bus.MADDR, bus.MWDATA} !== {1'b1, 4'b0001, 32'h10, 32'hA5A5_0001}) begin
          fails++;
          $display("[TB] FAIL wr_mregs got w=%b sel=%b addr=%h wdata=%h want 1 0001 10 a5a50001",
                   bus.MWRITE, bus.MSELx, bus.MADDR, bus.MWDATA);
        end
      end
      if (c == 4) begin
        tests++;
        if (bus.rdata !== 32'h0) begin
          fails++;
          $display("[TB] FAIL wr_rdata got %h want 0", bus.rdata);
        end
      end
      nextCycle();
    end
  endtask

  task automatic test_read_wait();
    logic [3:0] expGnt, expDone;
    applyStimulus(2, 1'b0, 32'h20, 32'h0, 4'b0100);
    bus.PREADY = 1'b0;
    bus.MRDATA = 32'hDEAD_BEEF;
    for (int c = 0; c < 9; c++) begin
      if (c == 1) bus.req = '0;
      if (c == 6) begin
        bus.PREADY = 1'b1;
        bus.MRDATA = 32'h1234_5678;
      end
      @(negedge PCLK);
      expGnt  = (c == 0) ? 4'b0100 : 4'b0000;
      expDone = (c == 7) ? 4'b0100 : 4'b0000;
      tests++;
      if ({bus.gnt, bus.done} !== {expGnt, expDone}) begin
        fails++;
        $display("[TB] FAIL rd_ctrl c%0d got gnt=%b done=%b want %b %b", c, bus.gnt, bus.done, expGnt, expDone);
      end
      if (c == 1) begin
        tests++;
        if ({bus.MWRITE, bus.MSELx, bus.MADDR} !== {1'b0, 4'b0100, 32'h20}) begin
          fails++;
          $display("[TB] FAIL rd_mregs got w=%b sel=%b addr=%h want 0 0100 20", bus.MWRITE, bus.MSELx, bus.MADDR);
        end
      end
      if (c == 6 || c == 7) begin
        tests++;
        if (bus.rdata !== ((c == 7) ? 32'h1234_5678 : 32'h0)) begin
          fails++;
          $display("[TB] FAIL rd_rdata c%0d got %h want %h", c, bus.rdata, (c == 7) ? 32'h1234_5678 : 32'h0);
        end
      end
      nextCycle();
    end
  endtask

  task automatic test_m_stability();
    logic [3:0] expGnt, expDone;
    int         mtransCount;
    mtransCount = 0;
    applyStimulus(0, 1'b1, 32'h40, 32'h11, 4'b0000);
    bus.PREADY = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c == 1) begin
        bus.req_addr[31:0]  = 32'hFFFF_FFF0;
        bus.req_wdata[31:0] = 32'h22;
      end
      if (c == 4) bus.PREADY = 1'b1;
      if (c == 5) bus.req = '0;
      @(negedge PCLK);
      if (bus.MTRANS === 1'b1) mtransCount++;
      expGnt  = (c == 0) ? 4'b0001 : 4'b0000;
      expDone = (c == 5) ? 4'b0001 : 4'b0000;
      tests++;
      if ({bus.gnt, bus.done} !== {expGnt, expDone}) begin
        fails++;
        $display("[TB] FAIL stab_ctrl c%0d got gnt=%b done=%b want %b %b", c, bus.gnt, bus.done, expGnt, expDone);
      end
      if (c >= 1 && c <= 5) begin
        tests++;
        if ({bus.MSELx, bus.MADDR, bus.MWDATA} !== {4'b0000, 32'h40, 32'h11}) begin
          fails++;
          $display("[TB] FAIL stab_mregs c%0d got sel=%b addr=%h wdata=%h want 0000 40 11",
                   c, bus.MSELx, bus.MADDR, bus.MWDATA);
        end
      end
      if (c == 5) begin
        tests++;
        if (bus.rdata !== 32'h1234_5678) begin
          fails++;
          $display("[TB] FAIL stab_rdata got %h want 12345678", bus.rdata);
        end
      end
      nextCycle();
    end
    tests++;
    if (mtransCount != 1) begin
      fails++;
      $display("[TB] FAIL stab_mtrans_count got %0d want 1", mtransCount);
    end
  endtask

  task automatic test_arbitration();
    logic [3:0]  expGnt, expDone;
    logic        expMtrans;
    logic [31:0] expAddr;
    int          w;
    PRESET = 1'b1;
    nextCycle();
    PRESET = 1'b0;
    bus.PREADY = 1'b1;
    for (int i = 0; i < 4; i++) bus.req_addr[i*32 +: 32] = 32'h100 + 32'(4 * i);
`ifdef APB_ARB_FIXED_PRIO_EN
    applyStimulus(1, 1'b1, 32'h104, 32'h0, 4'b0010);
    applyStimulus(3, 1'b1, 32'h10C, 32'h0, 4'b1000);
`else
    for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1, 32'h100 + 32'(4 * i), 32'h0, 4'b0001);
`endif
    for (int c = 0; c < 22; c++) begin
      if (c == 17) bus.req = '0;
      @(negedge PCLK);
      expGnt  = 4'b0000;
      expDone = 4'b0000;
      if (c % 4 == 0 && c <= 16) begin
`ifdef APB_ARB_FIXED_PRIO_EN
        w = 1;
`else
        w = (c / 4) % 4;
`endif
        expGnt[w] = 1'b1;
      end
      if (c % 4 == 0 && c >= 4 && c <= 20) begin
`ifdef APB_ARB_FIXED_PRIO_EN
        w = 1;
`else
        w = (c / 4 - 1) % 4;
`endif
        expDone[w] = 1'b1;
      end
      expMtrans = (c % 4 == 1) && (c <= 17);
      tests++;
      if ({bus.gnt, bus.done, bus.MTRANS} !== {expGnt, expDone, expMtrans}) begin
        fails++;
        $display("[TB] FAIL arb_ctrl c%0d got gnt=%b done=%b mtrans=%b want %b %b %b",
                 c, bus.gnt, bus.done, bus.MTRANS, expGnt, expDone, expMtrans);
      end
      if (expMtrans) begin
`ifdef APB_ARB_FIXED_PRIO_EN
        w = 1;
`else
        w = ((c - 1) / 4) % 4;
`endif
        expAddr = 32'h100 + 32'(4 * w);
        tests++;
        if (bus.MADDR !== expAddr) begin
          fails++;
          $display("[TB] FAIL arb_maddr c%0d got %h want %h", c, bus.MADDR, expAddr);
        end
      end
      nextCycle();
    end
  endtask

  task automatic test_reset_access();
    logic [3:0] expGnt, expDone;
    applyStimulus(1, 1'b0, 32'h30, 32'h0, 4'b0010);
    bus.PREADY = 1'b0;
    for (int c = 0; c < 13; c++) begin
      if (c == 1) bus.req = '0;
      if (c == 3) PRESET = 1'b1;
      if (c == 5) begin
        PRESET     = 1'b0;
        bus.PREADY = 1'b1;
      end
      if (c == 7) applyStimulus(3, 1'b1, 32'h3C, 32'h77, 4'b1000);
      if (c == 8) bus.req = '0;
      @(negedge PCLK);
      expGnt  = (c == 0) ? 4'b0010 : ((c == 7) ? 4'b1000 : 4'b0000);
      expDone = (c == 11) ? 4'b1000 : 4'b0000;
      tests++;
      if ({bus.gnt, bus.done} !== {expGnt, expDone}) begin
        fails++;
        $display("[TB] FAIL rst_acc_ctrl c%0d got gnt=%b done=%b want %b %b", c, bus.gnt, bus.done, expGnt, expDone);
      end
      if (c == 4) begin
        tests++;
        if ({bus.busy, bus.MTRANS, bus.MWRITE, bus.MSELx, bus.MADDR, bus.MWDATA, bus.rdata} !== 103'b0) begin
          fails++;
          $display("[TB] FAIL rst_acc_outs got busy=%b mtrans=%b w=%b sel=%b addr=%h wdata=%h rdata=%h want all 0",
                   bus.busy, bus.MTRANS, bus.MWRITE, bus.MSELx, bus.MADDR, bus.MWDATA, bus.rdata);
        end
      end
      if (c == 8) begin
        tests++;
        if ({bus.MTRANS, bus.MADDR, bus.MWDATA} !== {1'b1, 32'h3C, 32'h77}) begin
          fails++;
          $display("[TB] FAIL rst_acc_fresh got mtrans=%b addr=%h wdata=%h want 1 3c 77", bus.MTRANS, bus.MADDR, bus.MWDATA);
        end
      end
      nextCycle();
    end
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    PRESET        = 1'b1;
    bus.req       = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_sel   = '0;
    bus.PREADY    = 1'b0;
    bus.MRDATA    = '0;
    test_reset();
    test_single_write();
    test_read_wait();
    test_m_stability();
    test_arbitration();
    test_reset_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
